// File: rtl/root_pkg.sv
// Shared definitions for the eighth-root decoder.
//
// Contents:
//   root_state_t      FSM states (IDLE, ROOT)
//   IN_W / OUT_W      radicand and result widths (32 / 4)
//   ROOT_W            width of the first-stage square root (16)
//   REM_W             working remainder / trial width (18)
//   STAGEn_ITERS      iterations per square-root stage (16 / 8 / 4)
//   LATENCY           total iterations from accept to result (28)
//   stage_last_count  iteration counter load value for a given stage
package root_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ROOT = 1'b1
   } root_state_t;

   localparam int IN_W         = 32;
   localparam int OUT_W        = 4;
   localparam int ROOT_W       = IN_W / 2;
   localparam int REM_W        = 18;
   localparam int STAGE0_ITERS = 16;
   localparam int STAGE1_ITERS = 8;
   localparam int STAGE2_ITERS = 4;
   localparam int LATENCY      = STAGE0_ITERS + STAGE1_ITERS + STAGE2_ITERS;

   // Counter counts down to zero, so a stage of n iterations loads n-1.
   function automatic logic [3:0] stage_last_count(input logic [1:0] stage);
      case (stage)
         2'd0:    stage_last_count = 4'(STAGE0_ITERS - 1);
         2'd1:    stage_last_count = 4'(STAGE1_ITERS - 1);
         default: stage_last_count = 4'(STAGE2_ITERS - 1);
      endcase
   endfunction

endpackage

// File: rtl/isqrt_step.sv
// One digit of a restoring digit-by-digit integer square root (combinational).
//
// Ports:
//   rem        in  REM_W   current partial remainder
//   root       in  ROOT_W  root bits produced so far
//   bits       in  2       next two radicand bits (MSB first)
//   rem_next   out REM_W   remainder after this digit
//   root_next  out ROOT_W  root with the new bit appended
module isqrt_step
   import root_pkg::*;
(
   input  logic [REM_W-1:0]  rem,
   input  logic [ROOT_W-1:0] root,
   input  logic [1:0]        bits,
   output logic [REM_W-1:0]  rem_next,
   output logic [ROOT_W-1:0] root_next
);

   // Two spare bits so neither the shift nor the trial can overflow
   // before the compare; the result always fits back into REM_W.
   logic [REM_W+1:0] rem_sh;
   logic [REM_W+1:0] trial;
   logic             take;

   always_comb begin
      rem_sh    = {rem, bits};
      trial     = {{(REM_W - ROOT_W){1'b0}}, root, 2'b01};
      take      = (rem_sh >= trial);
      rem_next  = take ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
      root_next = {root[ROOT_W-2:0], take};
   end

endmodule

// File: rtl/eighth_root_decoder.sv
// Eighth-root decoder: floor(x^(1/8)) of a 32-bit value, computed as three
// chained integer square roots (32->16->8->4 bits), one root bit per clock.
//
// Ports:
//   clock      in  1      rising-edge clock
//   reset      in  1      asynchronous, active-low reset
//   i_value    in  32     radicand, sampled on accept
//   i_valid    in  1      input qualifier
//   i_ready    out 1      high while idle
//   o_value    out 4      floor 8th root, held until the next result
//   o_valid    out 1      one-cycle pulse when o_value / o_exact update
//   o_exact    out 1      input was a perfect 8th power
//   state_dbg  out 1      current FSM state
//
// Handshake: a value is accepted on a rising edge where i_valid && i_ready.
// i_valid while busy is ignored (no queueing). o_valid has no backpressure.
//
// Configuration: define EIGHTH_ROOT_EXACT_EN to build the exactness tracking;
// without it o_exact is constant 0 and the result timing is unchanged.
module eighth_root_decoder
   import root_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [IN_W-1:0]  i_value,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [OUT_W-1:0] o_value,
   output logic             o_valid,
   output logic             o_exact,
   output root_state_t      state_dbg
);

   root_state_t       state_q, state_d;
   logic [IN_W-1:0]   radicand_q, radicand_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [ROOT_W-1:0] root_q, root_d;
   logic [1:0]        stage_q, stage_d;
   logic [3:0]        count_q, count_d;
   logic [OUT_W-1:0]  o_value_q, o_value_d;
   logic              o_valid_q, o_valid_d;

   logic [REM_W-1:0]  step_rem;
   logic [ROOT_W-1:0] step_root;

`ifdef EIGHTH_ROOT_EXACT_EN
   // Sticky: some earlier stage left a nonzero remainder.
   logic nz_q, nz_d;
   logic o_exact_q, o_exact_d;
`endif

   isqrt_step u_step (
      .rem       (rem_q),
      .root      (root_q),
      .bits      (radicand_q[IN_W-1:IN_W-2]),
      .rem_next  (step_rem),
      .root_next (step_root)
   );

   always_comb begin
      state_d    = state_q;
      radicand_d = radicand_q;
      rem_d      = rem_q;
      root_d     = root_q;
      stage_d    = stage_q;
      count_d    = count_q;
      o_value_d  = o_value_q;
      o_valid_d  = 1'b0;
`ifdef EIGHTH_ROOT_EXACT_EN
      nz_d       = nz_q;
      o_exact_d  = o_exact_q;
`endif

      case (state_q)
         IDLE: begin
            if (i_valid) begin
               radicand_d = i_value;
               rem_d      = '0;
               root_d     = '0;
               stage_d    = 2'd0;
               count_d    = stage_last_count(2'd0);
               state_d    = ROOT;
`ifdef EIGHTH_ROOT_EXACT_EN
               nz_d       = 1'b0;
`endif
            end
         end

         ROOT: begin
            rem_d      = step_rem;
            root_d     = step_root;
            radicand_d = radicand_q << 2;
            count_d    = count_q - 4'd1;

            if (count_q == 4'd0) begin
               // Stage boundary: the root just produced becomes the next
               // radicand, left-aligned so its MSBs are consumed first.
               rem_d  = '0;
               root_d = '0;
`ifdef EIGHTH_ROOT_EXACT_EN
               nz_d   = nz_q | (step_rem != '0);
`endif
               case (stage_q)
                  2'd0: begin
                     radicand_d = {step_root, {(IN_W - ROOT_W){1'b0}}};
                     stage_d    = 2'd1;
                     count_d    = stage_last_count(2'd1);
                  end
                  2'd1: begin
                     radicand_d = {step_root[7:0], 24'd0};
                     stage_d    = 2'd2;
                     count_d    = stage_last_count(2'd2);
                  end
                  default: begin
                     o_value_d = step_root[OUT_W-1:0];
                     o_valid_d = 1'b1;
                     state_d   = IDLE;
`ifdef EIGHTH_ROOT_EXACT_EN
                     o_exact_d = !(nz_q || (step_rem != '0));
`endif
                  end
               endcase
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         radicand_q <= '0;
         rem_q      <= '0;
         root_q     <= '0;
         stage_q    <= '0;
         count_q    <= '0;
         o_value_q  <= '0;
         o_valid_q  <= 1'b0;
`ifdef EIGHTH_ROOT_EXACT_EN
         nz_q       <= 1'b0;
         o_exact_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         radicand_q <= radicand_d;
         rem_q      <= rem_d;
         root_q     <= root_d;
         stage_q    <= stage_d;
         count_q    <= count_d;
         o_value_q  <= o_value_d;
         o_valid_q  <= o_valid_d;
`ifdef EIGHTH_ROOT_EXACT_EN
         nz_q       <= nz_d;
         o_exact_q  <= o_exact_d;
`endif
      end
   end

   assign i_ready   = (state_q == IDLE);
   assign o_value   = o_value_q;
   assign o_valid   = o_valid_q;
   assign state_dbg = state_q;
`ifdef EIGHTH_ROOT_EXACT_EN
   assign o_exact   = o_exact_q;
`else
   assign o_exact   = 1'b0;
`endif

endmodule

// File: tb/tb_eighth_root_decoder.sv
// Self-checking bench for eighth_root_decoder. Expected results come from a
// brute-force search over k^8; each accepted input pushes {value, exact,
// accept edge} into exp_q and a negedge monitor pops and compares on o_valid.
module tb_eighth_root_decoder;
   import root_pkg::*;

   logic              clock;
   logic              reset;
   logic [IN_W-1:0]   i_value;
   logic              i_valid;
   logic              i_ready;
   logic [OUT_W-1:0]  o_value;
   logic              o_valid;
   logic              o_exact;
   root_state_t       state_dbg;

   // {root[3:0], exact, accept_edge[31:0]}
   logic [36:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cycle    = 0;
   bit          in_abort = 0;

   eighth_root_decoder dut (
      .clock     (clock),
      .reset     (reset),
      .i_value   (i_value),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .o_value   (o_value),
      .o_valid   (o_valid),
      .o_exact   (o_exact),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cycle <= cycle + 1;

   // ---------------- reference model ----------------
   function automatic logic [4:0] ref_root(input logic [31:0] x);
      longint unsigned pw;
      logic [3:0]      r;
      logic            ex;
      r  = 4'd0;
      ex = 1'b0;
      for (int k = 0; k < 16; k++) begin
         pw = 1;
         for (int j = 0; j < 8; j++) pw = pw * longint'(k);
         if (pw <= longint'(x)) begin
            r  = 4'(k);
            ex = (pw == longint'(x));
         end
      end
`ifndef EIGHTH_ROOT_EXACT_EN
      ex = 1'b0;
`endif
      return {r, ex};
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a negedge with i_valid about to be high; records the accept.
   task automatic push_if_accepted();
      logic [4:0] m;
      if (i_valid && i_ready) begin
         m = ref_root(i_value);
         exp_q.push_back({m, 32'(cycle + 1)});
      end
   endtask

   task automatic send(input logic [31:0] v);
      int waited = 0;
      @(negedge clock);
      while (!i_ready && waited < 40) begin
         @(negedge clock);
         waited++;
      end
      if (!i_ready) check("send_ready_timeout", 0, 1);
      i_value = v;
      i_valid = 1'b1;
      push_if_accepted();
      @(negedge clock);
      i_valid = 1'b0;
      check("ready_low_after_accept", i_ready, 0);
   endtask

   task automatic drain();
      int waited = 0;
      while (exp_q.size() != 0 && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      logic [36:0] e;
      if (reset && o_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_o_valid", o_valid, 0);
         end else begin
            e = exp_q.pop_front();
            check("o_value", o_value, e[36:33]);
            check("o_exact", o_exact, e[32]);
            check("latency", cycle - int'(e[31:0]), LATENCY);
            check("ready_with_valid", i_ready, 1);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      int          acc;
      int          k;
      longint unsigned pw;

      reset   = 1'b0;
      i_value = '0;
      i_valid = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_o_value", o_value, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_exact", o_exact, 0);
      check("rst_i_ready", i_ready, 1);
      check("rst_state", state_dbg, IDLE);
      reset = 1'b1;

      // Directed cases
      send(32'd0);          drain();
      send(32'd256);        drain();
      send(32'd255);        drain();
      send(32'd6561);       drain();
      send(32'd2562890625); drain();
      send(32'hFFFF_FFFF);  drain();

      // Random values plus neighbours of perfect 8th powers, random gaps
      for (int i = 0; i < 24; i++) begin
         k = $urandom_range(1, 15);
         pw = 1;
         for (int j = 0; j < 8; j++) pw = pw * longint'(k);
         case ($urandom_range(0, 3))
            0: v = 32'(pw);
            1: v = 32'(pw - 1);
            2: v = (k == 15) ? 32'(pw) + 32'($urandom_range(0, 1000)) : 32'(pw + 1);
            default: v = $urandom;
         endcase
         send(v);
         repeat ($urandom_range(0, 35)) @(negedge clock);
      end
      drain();

      // i_valid held high with a new value every cycle: only ready edges accept
      acc = 0;
      @(negedge clock);
      for (int i = 0; i < 90; i++) begin
         i_value = $urandom;
         i_valid = 1'b1;
         if (i_ready) acc++;
         push_if_accepted();
         @(negedge clock);
      end
      i_valid = 1'b0;
      check("stream_accepts", acc, 4);
      drain();

      // Reset in the middle of a computation
      send(32'd6561);
      repeat (9) @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("abort_o_valid", o_valid, 0);
      check("abort_o_value", o_value, 0);
      check("abort_o_exact", o_exact, 0);
      check("abort_i_ready", i_ready, 1);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      check("post_abort_queue", exp_q.size(), 0);
      check("post_abort_o_value", o_value, 0);
      send(32'd256);
      drain();
      send(32'hFFFF_FFFF);
      drain();

      repeat (5) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #2000000;
      n_errors++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/eighth_root_decoder.md
# eighth_root_decoder

Inverse of the team's square-square-square pipeline. It accepts a 32-bit value with a valid/ready handshake and returns floor(x^(1/8)) as a 4-bit result. It also reports whether the input was a perfect 8th power. It sits downstream of the x^8 pipeline to recover the original 4-bit operand, and doubles as its self-check. Internally it runs three successive digit-by-digit integer square roots (32→16→8→4 bits), producing one root bit per cycle.

## Interface
- Parameters: none. Widths are fixed by package constants: input 32, output 4.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_value  in  32  radicand; sampled only on accept
- i_valid  in  1  input qualifier
- i_ready  out  1  high when the block can accept; equals (state == IDLE)
- o_value  out  4  floor 8th root; holds its last value until the next result
- o_valid  out  1  one-cycle pulse when o_value/o_exact update
- o_exact  out  1  1 when i_value == o_value^8 (see Configuration)

## Operation
- Accept: i_valid && i_ready at a rising edge.
  - The edge loads the radicand, clears the remainder and root, sets stage=0 and bit count=15, and moves IDLE→ROOT.
- States: IDLE, ROOT. There is no output state; the result is registered on the final ROOT edge.
- ROOT iteration, one per edge:
  - rem = (rem<<2) | top two radicand bits
  - trial = (root<<2) | 1
  - if rem ≥ trial: rem −= trial, root = (root<<1) | 1; else root = root<<1
  - radicand <<= 2
- Stage lengths are 16, 8 and 4 iterations.
  - On the last iteration of a stage, the next stage loads radicand = new root, shifted so its MSBs lead (16→ and 8→ zero-extension to the working width).
  - On that edge, rem and root clear, and sticky flag nz |= (new rem != 0).
- Final iteration (stage 2, count 0):
  - o_value ← root[3:0], o_exact ← !(nz | rem_new != 0), o_valid ← 1.
  - The state returns to IDLE.
- Widths: the working remainder and trial are 18 bits, enough for the 32-bit stage (rem ≤ 2·root, root ≤ 16 bits). All arithmetic is unsigned with no wrap.
- i_valid while busy is ignored. The producer must hold data or tolerate the drop; the x^8 pipeline issues at most one value per 29 cycles in this use.
- Results:
  - 0 gives root 0, exact.
  - 0xFFFFFFFF gives 15, not exact. 16^8 does not fit in 32 bits, so 4 output bits are sufficient.

## Timing
- Reset values: o_value=0, o_valid=0, o_exact=0, state=IDLE (so i_ready=1), and all internal registers 0.
- Latency: accept at edge N; o_valid is high in the cycle after edge N+28 (28 iterations), for exactly one cycle.
- i_ready:
  - Low from edge N through edge N+28.
  - High in the same cycle o_valid is high, so back-to-back accepts give one result per 29 cycles.
- Reset asserted mid-ROOT aborts the computation immediately. No o_valid is produced for the aborted input, and the block is ready on reset release.
- o_valid is never asserted without a prior accept. There is no downstream backpressure; the consumer must take the pulse.

## Configuration
- EIGHTH_ROOT_EXACT_EN
  - Defined: the nz sticky flag and final remainder check are built, and o_exact is driven as specified.
  - Undefined: the nz logic is removed and o_exact is tied 1'b0. o_value and o_valid timing are unchanged.

## Structure
- Shared package root_pkg holds:
  - the state typedef (IDLE, ROOT)
  - IN_W=32, OUT_W=4, REM_W=18
  - per-stage iteration counts 16/8/4
  - the total latency constant 28
- One sub-module, isqrt_step: a combinational single-digit iteration.
  - Inputs: rem, root, and two radicand bits.
  - Outputs: rem_next, root_next.
- The top holds the FSM, counters and result registers.

## Test plan
- Reset, then i_value=0 with one-cycle i_valid → o_valid exactly 28 cycles after accept, o_value=0, o_exact=1.
- Inputs 256, 255, 6561 → o_value 2/exact, 1/not exact, 3/exact.
- 2562890625 (15^8) → 15, exact. 0xFFFFFFFF → 15, not exact.
- i_valid held high with a changing value every cycle → only the values present on ready edges are accepted, and one result every 29 cycles.
- Reset asserted at iteration 10 → no o_valid, outputs zero. A fresh accept after release gives the correct result.
- Build without EIGHTH_ROOT_EXACT_EN → the same o_value and latency for the cases above, with o_exact always 0.
